anim_ctrl: RTL

ANIM_CTRL -- requirements
Module: anim_ctrl

---
 rtl/anim_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/anim_ctrl.sv
// anim_ctrl: sprite animation sequencer with looping idle/walk and a one-shot, non-interruptible attack.
// Optional macro ANIM_PAUSE_EN adds a pause input that freezes frame_tick counting.
module anim_ctrl #(
   parameter int HOLD_FRAMES = 10,
   parameter int IDLE_STEPS  = 2,
   parameter int WALK_STEPS  = 4,
   parameter int ATK_STEPS   = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
`ifdef ANIM_PAUSE_EN
   input  logic       pause,
`endif
   input  logic       req_valid,
   input  logic [1:0] req_anim,
   output logic       req_ready,
   output logic [1:0] anim_sel,
   output logic [3:0] step,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WALK   = 2'd1,
      S_ATTACK = 2'd2
   } state_e;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);
   localparam logic [3:0] IDLE_LAST = 4'(IDLE_STEPS - 1);
   localparam logic [3:0] WALK_LAST = 4'(WALK_STEPS - 1);
   localparam logic [3:0] ATK_LAST  = 4'(ATK_STEPS - 1);

   state_e     state_q, state_d;
   logic [3:0] step_q, step_d;
   logic [7:0] cnt_q, cnt_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic       accept_s;
   logic       switch_s;
   logic       tick_s;
   logic       attack_end_s;
   logic [3:0] last_step_s;

   // State and registered outputs; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         step_q  <= 4'd0;
         cnt_q   <= 8'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Request decode and tick qualification.
   always_comb begin
      accept_s = req_valid && req_ready;
      // Reserved code 3 and a request for the current state are consumed without effect.
      switch_s = accept_s && (req_anim != 2'd3) && (req_anim != 2'(state_q));
`ifdef ANIM_PAUSE_EN
      tick_s   = frame_tick && !pause;
`else
      tick_s   = frame_tick;
`endif
      case (state_q)
         S_IDLE:   last_step_s = IDLE_LAST;
         S_WALK:   last_step_s = WALK_LAST;
         S_ATTACK: last_step_s = ATK_LAST;
         default:  last_step_s = IDLE_LAST;
      endcase
   end

   // Next-state: a state-changing request beats a coincident tick.
   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      cnt_d        = cnt_q;
      attack_end_s = 1'b0;
      if (switch_s) begin
         state_d = state_e'(req_anim);
         step_d  = 4'd0;
         cnt_d   = 8'd0;
      end else if (tick_s) begin
         if (cnt_q == HOLD_LAST) begin
            cnt_d = 8'd0;
            if (step_q == last_step_s) begin
               step_d = 4'd0;
               if (state_q == S_ATTACK) begin
                  state_d      = S_IDLE;
                  attack_end_s = 1'b1;
               end else begin
                  state_d = state_q;
               end
            end else begin
               step_d = step_q + 4'd1;
            end
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Outputs: ready from current state, busy/done staged for registering with the state.
   always_comb begin
      req_ready = (state_q != S_ATTACK);
      busy_d    = (state_d == S_ATTACK);
      done_d    = attack_end_s;
   end

   assign anim_sel = 2'(state_q);
   assign step     = step_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
